pong_pattern_sequencer: RTL

PONG_PATTERN_SEQUENCER -- requirements
Module: pong_pattern_sequencer

---
 rtl/pong_pattern_sequencer_pkg.sv | 11 +
 rtl/pong_pattern_sequencer_frame_divider.sv | 22 ++
 rtl/pong_pattern_sequencer.sv | 80 ++++++++
 3 files changed

// File: rtl/pong_pattern_sequencer_pkg.sv
// pong_pattern_sequencer_pkg: shared game states, pattern select codes and defaults
package pong_pattern_sequencer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SCORE, ST_OVER} state_t;
  localparam logic [1:0] SEL_RUN_A = 2'b00;
  localparam logic [1:0] SEL_RUN_B = 2'b01;
  localparam logic [1:0] SEL_SCORE = 2'b10;
  localparam logic [1:0] SEL_IDLE  = 2'b11;
  localparam int DEF_FRAME_DIV   = 25000;
  localparam int DEF_HOLD_FRAMES = 4;
  localparam int DEF_LIVES       = 3;
endpackage

// File: rtl/pong_pattern_sequencer_frame_divider.sv
// frame_divider: free-running 0..FRAME_DIV-1 counter with a registered strobe on the last count
module frame_divider import pong_pattern_sequencer_pkg::*; #(
  parameter int FRAME_DIV = DEF_FRAME_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);
  localparam int CW = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(FRAME_DIV - 2);
  logic [CW-1:0] cnt;
  // strobe is registered one count early so it is high while cnt == LAST
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt == LAST ? '0 : cnt + CW'(1);
      frame_tick <= cnt == PRE;
    end
endmodule

// File: rtl/pong_pattern_sequencer.sv
// pong_pattern_sequencer: game state machine selecting dot-matrix patterns from start/score/miss events
module pong_pattern_sequencer import pong_pattern_sequencer_pkg::*; #(
  parameter int FRAME_DIV   = DEF_FRAME_DIV,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int LIVES       = DEF_LIVES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       score_evt,
  input  logic       miss_evt,
  output logic [1:0] sel,
  output logic [1:0] lives,
  output logic [3:0] score,
  output logic       frame_tick
);
  state_t state, state_n;
  logic [1:0] sel_n, lives_n;
  logic [3:0] score_n, hold, hold_n;
  logic s1, s2, s3;
  logic start_p;
  frame_divider #(.FRAME_DIV(FRAME_DIV)) u_div (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick)
  );
  // s1/s2 synchronise the button, s3 remembers the previous level for edge detect
  assign start_p = s2 & ~s3;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= ST_IDLE;
      sel          <= SEL_IDLE;
      lives        <= 2'(LIVES);
      score        <= '0;
      hold         <= '0;
      {s3, s2, s1} <= '0;
    end else begin
      state        <= state_n;
      sel          <= sel_n;
      lives        <= lives_n;
      score        <= score_n;
      hold         <= hold_n;
      {s3, s2, s1} <= {s2, s1, start};
    end
  always_comb begin
    state_n = state;
    sel_n   = sel;
    lives_n = lives;
    score_n = score;
    hold_n  = hold;
    case (state)
      ST_IDLE, ST_OVER:
        if (start_p) begin
          state_n = ST_RUN;
          sel_n   = SEL_RUN_A;
          lives_n = 2'(LIVES);
          score_n = '0;
        end
      ST_RUN:
        if (miss_evt) begin
          lives_n = lives - 2'd1;
          state_n = lives == 2'd1 ? ST_OVER : ST_RUN;
          sel_n   = lives == 2'd1 ? SEL_IDLE : SEL_RUN_A;
        end else if (score_evt) begin
          state_n = ST_SCORE;
          sel_n   = SEL_SCORE;
          score_n = score == 4'hf ? score : score + 4'd1;
          hold_n  = 4'(HOLD_FRAMES);
        end else if (frame_tick)
          sel_n = sel == SEL_RUN_A ? SEL_RUN_B : SEL_RUN_A;
      ST_SCORE:
        if (frame_tick) begin
          hold_n  = hold - 4'd1;
          state_n = hold == 4'd1 ? ST_RUN : ST_SCORE;
          sel_n   = hold == 4'd1 ? SEL_RUN_A : SEL_SCORE;
        end
      default: ;
    endcase
  end
endmodule
